thread_dispatch_sched: RTL

Parametrised successor to the fixed 4-thread/2-ALU dispatcher in the multi-thread RISC-V core. Each cycle it selects up to NUM_ALUS distinct runnable threads out of NUM_THREADS and assigns them to ALU slots, using a rotating round-robin pointer. It adds a per-thread jump-penalty blackout and a dispatch-count perf counter. It sits between ex (hold/jump reporting) and the ifetch/id/ex per-thread muxing that consumes dispatch_threads.

---
 rtl/thread_dispatch_sched_pkg.sv | 19 +
 rtl/thread_dispatch_sched_rr_pick.sv | 36 +++
 rtl/thread_dispatch_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/thread_dispatch_sched_pkg.sv
// Shared configuration, types and helpers for the thread dispatcher.
// The optional starvation boost is enabled by defining STARVE_BOOST_EN.
package thread_dispatch_sched_pkg;
    localparam int NUM_THREADS  = 4;
    localparam int NUM_ALUS     = 2;
    localparam int TID_W        = 3;
    localparam int JUMP_PENALTY = 2;
    localparam int STARVE_LIMIT = 4;

    localparam int PEN_W    = (JUMP_PENALTY > 0) ? $clog2(JUMP_PENALTY + 1) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef logic [TID_W-1:0]       tid_t;
    typedef logic [NUM_THREADS-1:0] tmask_t;

    function automatic tmask_t tid_onehot(input tid_t t);
        return tmask_t'(1) << t;
    endfunction
endpackage

// File: rtl/thread_dispatch_sched_rr_pick.sv
// Rotating priority pick: first thread at or after ptr (mod NUM_THREADS)
// that is set in mask and clear in excl.
module thread_dispatch_sched_rr_pick
    import thread_dispatch_sched_pkg::*;
(
    input  tmask_t mask,
    input  tmask_t excl,
    input  tid_t   ptr,
    output tid_t   idx,
    output logic   found
);
    localparam int SUM_W = TID_W + 1;

    tmask_t            cand;
    tmask_t            rotated;
    logic [SUM_W-1:0]  sum;

    assign cand    = mask & ~excl;
    // Bit i of rotated is candidate (ptr + i) mod NUM_THREADS.
    assign rotated = tmask_t'({cand, cand} >> ptr);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                sum = {1'b0, ptr} + SUM_W'(i);
                if (sum >= SUM_W'(NUM_THREADS))
                    sum = sum - SUM_W'(NUM_THREADS);
                idx   = sum[TID_W-1:0];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/thread_dispatch_sched.sv
// Round-robin dispatch of up to NUM_ALUS runnable threads per cycle, with
// per-thread jump blackout and grant counter. Optional: STARVE_BOOST_EN.
module thread_dispatch_sched
    import thread_dispatch_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_THREADS-1:0]     thread_en,
    input  logic [NUM_THREADS-1:0]     hold,
    input  logic [NUM_THREADS-1:0]     jump_en,
    output tid_t [NUM_ALUS-1:0]        dispatch_threads,
    output logic [NUM_ALUS-1:0]        dispatch_valid,
    output logic [31:0]                dispatch_count
);
    if (NUM_ALUS < 1 || NUM_ALUS > NUM_THREADS) begin : g_bad_alus
        $error("NUM_ALUS must be in 1..NUM_THREADS");
    end
    if ((2 ** TID_W) < NUM_THREADS) begin : g_bad_tid_w
        $error("TID_W too narrow for NUM_THREADS");
    end

    tmask_t                eligible;
    tmask_t                granted;
    logic [PEN_W-1:0]      penalty_cnt_reg [NUM_THREADS];
    tid_t                  rr_ptr_reg;
    tid_t                  rr_ptr_next;
    tid_t [NUM_ALUS-1:0]   dispatch_threads_reg;
    logic [NUM_ALUS-1:0]   dispatch_valid_reg;
    logic [31:0]           dispatch_count_reg;

    tid_t                  boost_idx;
    logic                  boost_found;
    tmask_t                excl_mask [NUM_ALUS+1];
    tid_t                  rr_idx [NUM_ALUS];
    logic [NUM_ALUS-1:0]   rr_found;
    logic [NUM_ALUS-1:0]   stage_used;
    tid_t [NUM_ALUS-1:0]   slot_tid_next;
    logic [NUM_ALUS-1:0]   slot_valid_next;
    tid_t                  last_rr;
    logic                  any_rr;

    genvar gi;
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
        assign eligible[gi] = thread_en[gi] & ~hold[gi] & ~jump_en[gi]
                            & (penalty_cnt_reg[gi] == '0);

        // A fresh jump always reloads, even over an in-progress countdown.
        always_ff @(posedge clk) begin
            if (!rst)
                penalty_cnt_reg[gi] <= '0;
            else if (jump_en[gi])
                penalty_cnt_reg[gi] <= PEN_W'(JUMP_PENALTY);
            else if (penalty_cnt_reg[gi] != '0)
                penalty_cnt_reg[gi] <= penalty_cnt_reg[gi] - 1'b1;
        end
    end

`ifdef STARVE_BOOST_EN
    logic [STARVE_W-1:0] starve_cnt_reg [NUM_THREADS];
    tmask_t              starving;

    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_starve
        assign starving[gi] = eligible[gi]
                            & (starve_cnt_reg[gi] >= STARVE_W'(STARVE_LIMIT));

        always_ff @(posedge clk) begin
            if (!rst)
                starve_cnt_reg[gi] <= '0;
            else if (hold[gi] || granted[gi])
                starve_cnt_reg[gi] <= '0;
            else if (eligible[gi] && starve_cnt_reg[gi] != STARVE_W'(STARVE_LIMIT))
                starve_cnt_reg[gi] <= starve_cnt_reg[gi] + 1'b1;
        end
    end

    // Pointer fixed at 0 gives lowest-index priority among starving threads.
    thread_dispatch_sched_rr_pick u_boost_pick (
        .mask  (starving),
        .excl  ('0),
        .ptr   ('0),
        .idx   (boost_idx),
        .found (boost_found)
    );
`else
    assign boost_idx   = '0;
    assign boost_found = 1'b0;
`endif

    assign excl_mask[0] = boost_found ? tid_onehot(boost_idx) : '0;

    for (gi = 0; gi < NUM_ALUS; gi++) begin : g_stage
        thread_dispatch_sched_rr_pick u_rr_pick (
            .mask  (eligible),
            .excl  (excl_mask[gi]),
            .ptr   (rr_ptr_reg),
            .idx   (rr_idx[gi]),
            .found (rr_found[gi])
        );
        assign excl_mask[gi+1] = excl_mask[gi]
                               | (rr_found[gi] ? tid_onehot(rr_idx[gi]) : '0);

        // A boosted thread takes slot 0 and shifts the round-robin picks up.
        if (gi == 0) begin : g_slot0
            assign slot_valid_next[gi] = boost_found | rr_found[0];
            assign slot_tid_next[gi]   = boost_found ? boost_idx : rr_idx[0];
        end else begin : g_slotn
            assign slot_valid_next[gi] = boost_found ? rr_found[gi-1] : rr_found[gi];
            assign slot_tid_next[gi]   = boost_found ? rr_idx[gi-1]   : rr_idx[gi];
        end

        if (gi == NUM_ALUS - 1) begin : g_last
            assign stage_used[gi] = rr_found[gi] & ~boost_found;
        end else begin : g_notlast
            assign stage_used[gi] = rr_found[gi];
        end
    end

    assign granted = boost_found ? excl_mask[NUM_ALUS-1] : excl_mask[NUM_ALUS];

    always_comb begin
        last_rr = '0;
        any_rr  = 1'b0;
        for (int k = 0; k < NUM_ALUS; k++) begin
            if (stage_used[k]) begin
                last_rr = rr_idx[k];
                any_rr  = 1'b1;
            end
        end
    end

    assign rr_ptr_next = (last_rr == tid_t'(NUM_THREADS - 1)) ? '0 : last_rr + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_reg           <= '0;
            dispatch_threads_reg <= '0;
            dispatch_valid_reg   <= '0;
            dispatch_count_reg   <= '0;
        end else begin
            if (any_rr)
                rr_ptr_reg <= rr_ptr_next;
            dispatch_threads_reg <= slot_tid_next;
            dispatch_valid_reg   <= slot_valid_next;
            dispatch_count_reg   <= dispatch_count_reg + 32'($countones(granted));
        end
    end

    assign dispatch_threads = dispatch_threads_reg;
    assign dispatch_valid   = dispatch_valid_reg;
    assign dispatch_count   = dispatch_count_reg;
endmodule
